// File: rtl/sbox_pkg.sv
// Shared definitions for the editable S-box bank: config opcodes, FSM states
// and the DES S1..S8 default tables, indexed by flat {row, col}.
package sbox_pkg;

    typedef enum logic [1:0] {
        CFG_WR      = 2'b00,
        CFG_RD      = 2'b01,
        CFG_RESTORE = 2'b10,
        CFG_RSVD    = 2'b11
    } cfg_op_e;

    typedef enum logic {
        IDLE    = 1'b0,
        RESTORE = 1'b1
    } state_e;

    localparam int DES_BOXES = 8;
    localparam int DES_DEPTH = 64;

    localparam int DES_SBOX [DES_BOXES][DES_DEPTH] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

    // Boxes beyond the eight DES tables default to zero.
    function automatic logic [3:0] des_default(input int box, input int idx);
        if (box < 0 || box >= DES_BOXES || idx < 0 || idx >= DES_DEPTH)
            return 4'd0;
        return 4'(DES_SBOX[box][idx]);
    endfunction

endpackage

// File: rtl/sbox_table.sv
// One editable substitution box: a register array with a write/restore port
// and two combinational read ports (datapath lookup and config read-back).
module sbox_table
    import sbox_pkg::*;
#(
    parameter int IN_W    = 6,
    parameter int OUT_W   = 4,
    parameter int BOX_IDX = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IN_W-1:0]  wr_idx,
    input  logic [OUT_W-1:0] wr_data,
    input  logic             restore_en,
    input  logic [IN_W-1:0]  restore_idx,
    input  logic [IN_W-1:0]  lk_idx,
    output logic [OUT_W-1:0] lk_data,
    input  logic [IN_W-1:0]  cfg_idx,
    output logic [OUT_W-1:0] cfg_data
);

    localparam int DEPTH  = 1 << IN_W;
    localparam bit IS_DES = (IN_W == 6) && (OUT_W == 4);

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [OUT_W-1:0] mem_d [DEPTH];

    function automatic logic [OUT_W-1:0] entry_default(input int idx);
        logic [OUT_W-1:0] v;
        v = '0;
        if (IS_DES)
            v = OUT_W'(des_default(BOX_IDX, idx));
        return v;
    endfunction

    always_comb begin
        mem_d = mem_q;
        if (wr_en)
            mem_d[wr_idx] = wr_data;
        if (restore_en)
            mem_d[restore_idx] = entry_default(int'(restore_idx));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= entry_default(i);
        end else begin
            mem_q <= mem_d;
        end
    end

    // Reads come from the current array, so a write on the same edge is not seen.
    assign lk_data  = mem_q[lk_idx];
    assign cfg_data = mem_q[cfg_idx];

endmodule

// File: rtl/sbox_bank.sv
// Bank of NUM_SBOX editable S-boxes between key-XOR and P-permutation:
// registered lookup path, config write/read/restore port and restore FSM.
module sbox_bank
    import sbox_pkg::*;
#(
    parameter int NUM_SBOX = 8,
    parameter int IN_W     = 6,
    parameter int OUT_W    = 4,
    parameter int SEL_W    = (NUM_SBOX > 1) ? $clog2(NUM_SBOX) : 1,
    localparam int DEPTH   = 1 << IN_W,
    localparam int COL_W   = IN_W - 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_SBOX*IN_W-1:0]  in_data,
    output logic                      out_valid,
    output logic [NUM_SBOX*OUT_W-1:0] out_data,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [1:0]                cfg_op,
    input  logic [SEL_W-1:0]          cfg_box,
    input  logic [1:0]                cfg_row,
    input  logic [COL_W-1:0]          cfg_col,
    input  logic [OUT_W-1:0]          cfg_wdata,
    output logic                      cfg_rvalid,
    output logic [OUT_W-1:0]          cfg_rdata,
    output logic                      busy
);

    state_e                    state_q, state_d;
    logic [IN_W-1:0]           cnt_q, cnt_d;
    logic                      out_valid_q, out_valid_d;
    logic [NUM_SBOX*OUT_W-1:0] out_data_q, out_data_d;
    logic                      cfg_rvalid_q, cfg_rvalid_d;
    logic [OUT_W-1:0]          cfg_rdata_q, cfg_rdata_d;

    logic                      lk_fire;
    logic                      cfg_fire;
    logic                      restore_en;
    logic [IN_W-1:0]           cfg_idx;
    logic [NUM_SBOX*OUT_W-1:0] lk_result;
    logic [OUT_W-1:0]          cfg_rd_arr [NUM_SBOX];
    logic [OUT_W-1:0]          cfg_sel;

    assign in_ready  = (state_q == IDLE);
    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q == RESTORE);
    assign lk_fire   = in_valid && in_ready;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign cfg_idx   = {cfg_row, cfg_col};

    for (genvar k = 0; k < NUM_SBOX; k++) begin : g_box
        logic [IN_W-1:0] d;
        logic [IN_W-1:0] lk_idx;
        logic            wr_en;

        // Outer bits pick the row, inner bits the column.
        assign d      = in_data[k*IN_W +: IN_W];
        assign lk_idx = {d[IN_W-1], d[0], d[IN_W-2:1]};
        assign wr_en  = cfg_fire && (cfg_op == CFG_WR) && (int'(cfg_box) == k);

        sbox_table #(
            .IN_W    (IN_W),
            .OUT_W   (OUT_W),
            .BOX_IDX (k)
        ) u_table (
            .clk         (clk),
            .rst         (rst),
            .wr_en       (wr_en),
            .wr_idx      (cfg_idx),
            .wr_data     (cfg_wdata),
            .restore_en  (restore_en),
            .restore_idx (cnt_q),
            .lk_idx      (lk_idx),
            .lk_data     (lk_result[k*OUT_W +: OUT_W]),
            .cfg_idx     (cfg_idx),
            .cfg_data    (cfg_rd_arr[k])
        );
    end

    // Out-of-range box numbers match no table and read back as zero.
    always_comb begin
        cfg_sel = '0;
        for (int i = 0; i < NUM_SBOX; i++) begin
            if (int'(cfg_box) == i)
                cfg_sel = cfg_rd_arr[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        restore_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_fire && (cfg_op == CFG_RESTORE)) begin
                    state_d = RESTORE;
                    cnt_d   = '0;
                end
            end
            RESTORE: begin
                restore_en = 1'b1;
                cnt_d      = cnt_q + IN_W'(1);
                if (cnt_q == IN_W'(DEPTH - 1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid_d  = lk_fire;
        out_data_d   = lk_fire ? lk_result : out_data_q;
        cfg_rvalid_d = cfg_fire && (cfg_op == CFG_RD);
        cfg_rdata_d  = cfg_rvalid_d ? cfg_sel : cfg_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            cfg_rvalid_q <= 1'b0;
            cfg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            cfg_rvalid_q <= cfg_rvalid_d;
            cfg_rdata_q  <= cfg_rdata_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign cfg_rvalid = cfg_rvalid_q;
    assign cfg_rdata  = cfg_rdata_q;

endmodule

// File: doc/sbox_bank.md
Name: sbox_bank

Overview:
- Parametrised bank of NUM_SBOX editable substitution boxes, each a 4-row by 2^(IN_W-2)-column table of OUT_W-bit entries.
- Successor to the single-box editable S-box. Adds a registered lookup path with valid/ready handshake, a config port with write, read-back and restore-defaults operations, and a restore state machine.
- Sits between the expansion/key-XOR stage and the P-permutation inside the DES round datapath.
- Defaults are the standard DES S1..S8 tables.

Parameters:
- NUM_SBOX, 8, number of boxes in the bank.
- IN_W, 6, input bits per box. Row is 2 bits, column is IN_W-2 bits.
- OUT_W, 4, output bits per box.
- Localparams: DEPTH = 2^IN_W; SEL_W = max(1, clog2(NUM_SBOX)); COL_W = IN_W-2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  lookup request valid.
- in_ready  out  1  lookup accepted when in_valid && in_ready.
- in_data  in  NUM_SBOX*IN_W  box k uses bits [k*IN_W +: IN_W].
- out_valid  out  1  lookup result valid. Single-cycle pulse per accepted request.
- out_data  out  NUM_SBOX*OUT_W  box k result at [k*OUT_W +: OUT_W].
- cfg_valid  in  1  config request valid.
- cfg_ready  out  1  config accepted when cfg_valid && cfg_ready.
- cfg_op  in  2  00 write, 01 read, 10 restore-all, 11 reserved (accepted, no-op).
- cfg_box  in  SEL_W  target box.
- cfg_row  in  2  target row.
- cfg_col  in  COL_W  target column.
- cfg_wdata  in  OUT_W  write data.
- cfg_rvalid  out  1  read-back data valid. Single-cycle pulse.
- cfg_rdata  out  OUT_W  read-back data.
- busy  out  1  restore in progress.

Behaviour:
- Clock and reset: single clock. Reset is asynchronous, active-high, on port rst.
- Reset state:
  - All table entries load their defaults.
  - For IN_W=6, OUT_W=4: box k holds DES S(k+1) for k<8; boxes k>=8 hold zero. For any other parameter set, all entries are zero.
  - out_valid=0, out_data=0, cfg_rvalid=0, cfg_rdata=0, busy=0, FSM=IDLE, restore counter=0.
- Addressing:
  - Lookup row = {d[IN_W-1], d[0]}; column = d[IN_W-2:1].
  - Flat entry index = {row, col}.
- Lookup path:
  - Latency 1 cycle. An accepted request at edge N gives out_valid=1 and out_data valid after edge N+1.
  - No output backpressure. out_data holds its last value when out_valid=0.
  - in_ready = (FSM==IDLE).
- Config write:
  - Takes effect at the accepting edge.
  - A lookup accepted on the same edge returns the OLD entry (read-before-write). The next lookup sees the new value.
  - A write with cfg_box >= NUM_SBOX is ignored.
- Config read:
  - cfg_rvalid=1 and cfg_rdata=entry one cycle after acceptance.
  - cfg_box >= NUM_SBOX returns 0 with cfg_rvalid=1.
- Only one cfg op is handled per cycle. cfg_ready = (FSM==IDLE).
- FSM:
  - IDLE -> RESTORE on an accepted restore-all op. Counter cleared to 0, busy=1 from the next cycle.
  - In RESTORE, each cycle: entry[counter] of every box gets its default; counter increments.
  - RESTORE -> IDLE when counter==DEPTH-1. That cycle writes the last entry; busy=0 after the edge. Total busy time is DEPTH cycles.
  - During RESTORE: in_ready=0, cfg_ready=0.
  - A lookup accepted on the same edge as the restore op completes normally with pre-restore data.
- Reset mid-restore: immediately IDLE, busy=0, all tables at defaults.
- Reserved op: accepted, no state change, no rvalid.

Decomposition:
- Package sbox_pkg holds:
  - DES default table constant: 8 boxes x 64 entries x 4 bits, indexed by flat {row,col}.
  - cfg_op encodings (CFG_WR, CFG_RD, CFG_RESTORE, CFG_RSVD).
  - FSM state typedef (IDLE, RESTORE).
  - Helper function returning the default for a (box, index) pair.
- Natural sub-module: sbox_table. It holds one box's register array, with write port, combinational lookup read and combinational cfg read. It is instantiated NUM_SBOX times under a generate loop. The FSM, handshakes and output registers live in the top.

Test Plan:
- Reset, then lookup in_data with all boxes = 6'b000000 -> after 1 cycle out_valid=1. Box0 (S1) = 14, box4 (S5) = 2.
- Lookup box4 = 6'b100001 (row 3, col 0) -> 11. Box4 = 6'b011110 (row 0, col 15) -> 9.
- Write box4 row0 col0 = 7 while the same edge accepts a lookup of box4=000000 -> that result is 2. The next lookup returns 7. A cfg read of the entry returns cfg_rvalid=1, cfg_rdata=7 one cycle later.
- Restore-all after the edit -> busy=1 for exactly 64 cycles, in_ready=cfg_ready=0 throughout. Afterwards box4 000000 -> 2.
- Assert rst at restore cycle 20 -> busy=0 and FSM IDLE immediately. Edited entries read back as defaults. Lookups accepted on the first cycle after release.
- Read and write with cfg_box=8 (NUM_SBOX=8, SEL_W=4 override) -> write ignored (tables unchanged). Read gives cfg_rvalid=1, cfg_rdata=0.
